// File: rtl/reg_fifo_if.sv
// Producer/consumer bundle for reg_fifo.
// Write side enqueues words, read side sees the head word.
interface reg_fifo_if #(
    parameter int DATA_WIDTH = 16,
    parameter int PTR_WIDTH  = 3
);
    logic [DATA_WIDTH-1:0] writeData;
    logic                  writeEn;
    logic                  readEn;
    logic [DATA_WIDTH-1:0] readData;
    logic                  full;
    logic                  empty;
    logic [PTR_WIDTH:0]    count;
    logic                  err;

    modport master (
        output writeData, writeEn, readEn,
        input  readData, full, empty, count, err
    );

    modport slave (
        input  writeData, writeEn, readEn,
        output readData, full, empty, count, err
    );
endinterface

// File: rtl/reg_fifo.sv
// Synchronous first-word-fall-through FIFO on enabled registers.
// Flags come straight from the registered occupancy count.
module reg_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = 3
) (
    input logic         clk,
    input logic         rst,
    reg_fifo_if.slave   bus
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wrPtr;
    logic [PTR_WIDTH-1:0]  rdPtr;
    logic [PTR_WIDTH:0]    cnt;
    logic                  errQ;
    logic                  isFull;
    logic                  isEmpty;
    logic                  pushOk;
    logic                  popOk;
    logic                  errNext;

    // Accept/reject decisions from the state seen at this edge
    always_comb begin
        isFull  = (cnt == (PTR_WIDTH+1)'(DEPTH));
        isEmpty = (cnt == '0);
        pushOk  = bus.writeEn & (~isFull | bus.readEn);
        popOk   = bus.readEn & ~isEmpty;
        errNext = (bus.writeEn & isFull & ~bus.readEn)
                | (bus.readEn & isEmpty);
    end

    // Storage: never cleared, written only on an accepted push
    always_ff @(posedge clk) begin
        if (!rst && pushOk) begin
            mem[wrPtr] <= bus.writeData;
        end
    end

    // Pointers, occupancy and the one-cycle error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
            errQ  <= 1'b0;
        end else begin
            errQ <= errNext;
            if (pushOk) begin
                wrPtr <= wrPtr + PTR_WIDTH'(1);
            end
            if (popOk) begin
                rdPtr <= rdPtr + PTR_WIDTH'(1);
            end
            unique case ({pushOk, popOk})
                2'b10:   cnt <= cnt + (PTR_WIDTH+1)'(1);
                2'b01:   cnt <= cnt - (PTR_WIDTH+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Head word falls through; forced to zero when nothing is queued
    always_comb begin
        bus.readData = isEmpty ? '0 : mem[rdPtr];
        bus.full     = isFull;
        bus.empty    = isEmpty;
        bus.count    = cnt;
        bus.err      = errQ;
    end
endmodule

// File: tb/tb_reg_fifo.sv
// Bench for reg_fifo: fixed vector table, directed sequences
// and random traffic against a queue-based reference.
module tb_reg_fifo;
    localparam int DW = 16;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nVec = 0;
    int   nBad = 0;

    logic [DW-1:0] q [$];
    logic          errM = 1'b0;

    always #5 clk = ~clk;

    reg_fifo_if #(.DATA_WIDTH(DW), .PTR_WIDTH(3)) bus ();

    reg_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          r;
        logic          we;
        logic          re;
        logic [DW-1:0] wd;
        int            expCnt;
        logic [DW-1:0] expRd;
        logic          expErr;
    } vec_t;

    vec_t tbl [$];

    task automatic cmp(input string name, input int act, input int exp);
        nVec++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // one clock: drive at negedge, model at posedge, sample at next negedge
    task automatic step(input logic r, input logic we, input logic re,
                        input logic [DW-1:0] wd);
        int  n;
        bit  pushOk;
        bit  popOk;
        rst = r;
        bus.writeEn = we;
        bus.readEn = re;
        bus.writeData = wd;
        @(posedge clk);
        n = q.size();
        if (r) begin
            q.delete();
            errM = 1'b0;
        end else begin
            pushOk = we && (n < DEPTH || re);
            popOk = re && n > 0;
            errM = (we && n == DEPTH && !re) || (re && n == 0);
            if (popOk) void'(q.pop_front());
            if (pushOk) q.push_back(wd);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.writeEn = 1'b0;
        bus.readEn = 1'b0;
    endtask

    task automatic checkModel(input string tag);
        logic [DW-1:0] head;
        head = (q.size() > 0) ? q[0] : '0;
        cmp({tag, ".count"}, int'(bus.count), q.size());
        cmp({tag, ".full"}, int'(bus.full), int'(q.size() == DEPTH));
        cmp({tag, ".empty"}, int'(bus.empty), int'(q.size() == 0));
        cmp({tag, ".err"}, int'(bus.err), int'(errM));
        cmp({tag, ".readData"}, int'(bus.readData), int'(head));
    endtask

    initial begin
        bus.writeEn = 1'b0;
        bus.readEn = 1'b0;
        bus.writeData = '0;

        // table: inputs then expected state after the edge
        tbl.push_back('{1, 0, 0, 16'h0000, 0, 16'h0000, 0});
        tbl.push_back('{0, 0, 1, 16'h0000, 0, 16'h0000, 1});
        tbl.push_back('{0, 0, 0, 16'h0000, 0, 16'h0000, 0});
        for (int i = 1; i <= 8; i++)
            tbl.push_back('{0, 1, 0, DW'(i), i, 16'h0001, 0});
        tbl.push_back('{0, 1, 0, 16'hDEAD, 8, 16'h0001, 1});
        tbl.push_back('{0, 0, 0, 16'h0000, 8, 16'h0001, 0});
        tbl.push_back('{0, 1, 1, 16'hBEEF, 8, 16'h0002, 0});
        tbl.push_back('{0, 0, 1, 16'h0000, 7, 16'h0003, 0});
        tbl.push_back('{1, 1, 1, 16'h0055, 0, 16'h0000, 0});
        tbl.push_back('{0, 1, 0, 16'h00AA, 1, 16'h00AA, 0});
        tbl.push_back('{0, 0, 1, 16'h0000, 0, 16'h0000, 0});
        tbl.push_back('{0, 1, 1, 16'h1234, 1, 16'h1234, 1});
        tbl.push_back('{0, 0, 1, 16'h0000, 0, 16'h0000, 0});

        @(negedge clk);
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].we, tbl[i].re, tbl[i].wd);
            cmp($sformatf("tbl%0d.count", i), int'(bus.count), tbl[i].expCnt);
            cmp($sformatf("tbl%0d.readData", i), int'(bus.readData),
                int'(tbl[i].expRd));
            cmp($sformatf("tbl%0d.err", i), int'(bus.err), int'(tbl[i].expErr));
            cmp($sformatf("tbl%0d.full", i), int'(bus.full),
                int'(tbl[i].expCnt == DEPTH));
            cmp($sformatf("tbl%0d.empty", i), int'(bus.empty),
                int'(tbl[i].expCnt == 0));
        end

        // fill, overflow, full push+pop, then drain in order
        step(1, 0, 0, '0);
        checkModel("rst");
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 0, DW'(i));
            checkModel("fill");
        end
        step(0, 1, 0, 16'hDEAD);
        checkModel("ovf");
        step(0, 1, 1, 16'hBEEF);
        checkModel("fullpp");
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 1, '0);
            checkModel("drain");
        end
        step(0, 0, 1, '0);
        checkModel("udf");

        // hold three entries across many pointer wraps
        for (int i = 0; i < 3; i++) step(0, 1, 0, DW'(16'h0100 + i));
        checkModel("pre");
        for (int i = 3; i < 23; i++) begin
            step(0, 1, 1, DW'(16'h0100 + i));
            checkModel("wrap");
        end

        // reset with five queued and a push in flight
        while (q.size() < 5) step(0, 1, 0, 16'h0777);
        checkModel("five");
        step(1, 1, 0, 16'h0999);
        checkModel("midrst");
        step(0, 1, 0, 16'h00AA);
        checkModel("afterrst");

        // random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 60) == 0), 1'($urandom), 1'($urandom),
                 DW'($urandom));
            checkModel("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end
endmodule
